// File: rtl/prefix_sum_pkg.sv
// Shared types and helpers for the streaming mask prefix-sum block.
package prefix_sum_pkg;

  // Default geometry; instances override SIZE and CNT_W as needed.
  localparam int DEF_SIZE  = 64;
  localparam int DEF_CNT_W = 16;
  localparam int LVL       = $clog2(DEF_SIZE);

  typedef logic [DEF_CNT_W-1:0] count_t;

  // Saturating add result: clamped value plus a flag raised when clamping
  // occurred. Widths up to 31 bits are handled through a 32-bit carrier.
  typedef struct packed {
    logic        sat;
    logic [31:0] val;
  } sat_res_t;

  // Unsigned a+b clamped to 2^w-1.
  function automatic sat_res_t sat_add(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max_val;
    sat_res_t    res;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << w) - 33'd1;
    res.sat = (sum > max_val);
    res.val = res.sat ? max_val[31:0] : sum[31:0];
    return res;
  endfunction

endpackage

// File: rtl/prefix_sum_tree.sv
// Combinational inclusive popcount scan of a mask: up-sweep builds the
// power-of-two partial sums, down-sweep distributes them to every position.
module prefix_sum_tree
  import prefix_sum_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  localparam int TW  = $clog2(SIZE) + 1
) (
  input  logic [SIZE-1:0]         mask_i,
  output logic [SIZE-1:0][TW-1:0] l_o
);

  localparam int LV = $clog2(SIZE);

  logic [TW-1:0] node [SIZE];

  // Two-phase scan over the node array; l_o[j] = popcount(mask_i[j:0]).
  always_comb begin
    // NOTE: every element is assigned before any conditional update, so the
    // block is purely combinational and no latch can be inferred.
    for (int i = 0; i < SIZE; i++) begin
      node[i] = {{(TW-1){1'b0}}, mask_i[i]};
    end
    // Up-sweep: node[i] at the end of each 2^(d+1) block collects that block.
    for (int d = 0; d < LV; d++) begin
      for (int i = 0; i < SIZE; i++) begin
        if ((i & ((2 << d) - 1)) == ((2 << d) - 1)) begin
          node[i] = node[i] + node[(i >= (1 << d)) ? i - (1 << d) : 0];
        end
      end
    end
    // Down-sweep: fill the mid-block positions from the block to their left.
    for (int d = LV - 2; d >= 0; d--) begin
      for (int i = 0; i < SIZE; i++) begin
        if ((i >= (2 << d)) && ((i & ((2 << d) - 1)) == ((1 << d) - 1))) begin
          node[i] = node[i] + node[(i >= (1 << d)) ? i - (1 << d) : 0];
        end
      end
    end
    for (int i = 0; i < SIZE; i++) begin
      l_o[i] = node[i];
    end
  end

endmodule

// File: rtl/prefix_sum_stream.sv
// Three-stage streaming prefix sum: S1 captures the beat, S2 captures the
// local scan from the tree, S3 adds the frame carry with saturation.
module prefix_sum_stream
  import prefix_sum_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [SIZE-1:0]            in_mask_i,
  input  logic                       in_first_i,
  input  logic                       in_excl_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [SIZE-1:0][CNT_W-1:0] out_sum_o,
  output logic [CNT_W-1:0]           out_total_o,
  output logic                       out_first_o,
  output logic                       out_ovf_o
);

  localparam int TW = $clog2(SIZE) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Stage advance strobes.
  logic go1, go2, go3;

  // S1: raw beat.
  logic            v1_q, v1_d;
  logic [SIZE-1:0] mask1_q, mask1_d;
  logic            first1_q, first1_d;
  logic            excl1_q, excl1_d;

  // S2: local inclusive scan.
  logic [SIZE-1:0][TW-1:0] l_tree;
  logic                    v2_q, v2_d;
  logic [SIZE-1:0][TW-1:0] l2_q, l2_d;
  logic                    first2_q, first2_d;
  logic                    excl2_q, excl2_d;

  // S3: results. total_q doubles as the running carry, since the carry is
  // by definition the total of the most recently loaded beat.
  logic                v3_q, v3_d;
  cnt_t [SIZE-1:0]     sum_q, sum_d;
  cnt_t                total_q, total_d;
  logic                first3_q, first3_d;
  logic                ovf_q, ovf_d;

  // S3 working values.
  cnt_t           carry_in;
  cnt_t           src;
  logic [CNT_W:0] add_res;
  logic           sat_any;

  // {saturated, value} of a+b at CNT_W bits.
  function automatic logic [CNT_W:0] sat_cnt(input cnt_t a, input cnt_t b);
    sat_res_t r;
    r = sat_add(32'(a), 32'(b), CNT_W);
    return {r.sat, r.val[CNT_W-1:0]};
  endfunction

  prefix_sum_tree #(.SIZE(SIZE)) u_tree (
    .mask_i (mask1_q),
    .l_o    (l_tree)
  );

  // Handshake: a stage moves forward when the slot after it is empty or
  // is itself moving forward this cycle.
  always_comb begin
    go3        = v2_q & (~v3_q | out_ready_i);
    go2        = v1_q & (~v2_q | go3);
    in_ready_o = ~v1_q | ~v2_q | go3;
    go1        = in_valid_i & in_ready_o;
    v1_d       = go1 | (v1_q & ~go2);
    v2_d       = go2 | (v2_q & ~go3);
    v3_d       = go3 | (v3_q & ~out_ready_i);
  end

  // S1/S2 data capture; each stage holds while it is not loading.
  always_comb begin
    mask1_d  = go1 ? in_mask_i  : mask1_q;
    first1_d = go1 ? in_first_i : first1_q;
    excl1_d  = go1 ? in_excl_i  : excl1_q;
    l2_d     = go2 ? l_tree     : l2_q;
    first2_d = go2 ? first1_q   : first2_q;
    excl2_d  = go2 ? excl1_q    : excl2_q;
  end

  // S3: add the carry (zero on a frame start), saturate, update sticky ovf.
  always_comb begin
    sum_d    = sum_q;
    total_d  = total_q;
    first3_d = first3_q;
    ovf_d    = ovf_q;
    carry_in = first2_q ? '0 : total_q;
    sat_any  = 1'b0;
    src      = '0;
    add_res  = '0;
    if (go3) begin
      for (int j = 0; j < SIZE; j++) begin
        // Exclusive position j uses the inclusive count one bit to the right.
        if (excl2_q) begin
          src = (j == 0) ? '0 : cnt_t'(l2_q[(j > 0) ? j - 1 : 0]);
        end else begin
          src = cnt_t'(l2_q[j]);
        end
        add_res  = sat_cnt(carry_in, src);
        sum_d[j] = add_res[CNT_W-1:0];
        sat_any  = sat_any | add_res[CNT_W];
      end
      add_res  = sat_cnt(carry_in, cnt_t'(l2_q[SIZE-1]));
      total_d  = add_res[CNT_W-1:0];
      sat_any  = sat_any | add_res[CNT_W];
      first3_d = first2_q;
      ovf_d    = (first2_q ? 1'b0 : ovf_q) | sat_any;
    end
  end

  // Valid bits for all three stages.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  // S1/S2 payload registers.
  always_ff @(posedge clk_i) begin
    // NOTE: payload flops are not reset; their valid bits qualify them,
    // which keeps reset fan-out off the wide datapath.
    mask1_q  <= mask1_d;
    first1_q <= first1_d;
    excl1_q  <= excl1_d;
    l2_q     <= l2_d;
    first2_q <= first2_d;
    excl2_q  <= excl2_d;
  end

  // S3 result, carry and overflow registers; reset to a clean frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q    <= '0;
      total_q  <= '0;
      first3_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      total_q  <= total_d;
      first3_q <= first3_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid_o = v3_q;
  assign out_sum_o   = sum_q;
  assign out_total_o = total_q;
  assign out_first_o = first3_q;
  assign out_ovf_o   = ovf_q;

endmodule
